// File: rtl/divisor_secuencial_pkg.sv
// rtl/divisor_secuencial_pkg.sv - shared width constants and FSM encoding for the sequential divider
package divisor_secuencial_pkg;

    localparam int N_DEF = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } estado_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_width(N_DEF);

endpackage

// File: rtl/divisor_etapa.sv
// rtl/divisor_etapa.sv - one combinational restoring-division step
module divisor_etapa #(
    parameter int N = 25
) (
    input  logic [N:0]   r,
    input  logic         dato_bit,
    input  logic [N-1:0] d,
    output logic [N:0]   r_nuevo,
    output logic         q_bit
);

    logic [N:0] t;

    // r[N] stays zero while R < D; folding it in keeps the step exact for any R.
    always_comb begin
        t       = {r[N-1:0], dato_bit};
        q_bit   = r[N] || (t >= {1'b0, d});
        r_nuevo = q_bit ? (t - {1'b0, d}) : t;
    end

endmodule

// File: rtl/divisor_secuencial.sv
// rtl/divisor_secuencial.sv - sequential unsigned restoring divider, 2N/N bits (macro DIVISOR_SATURA_EN)
module divisor_secuencial
    import divisor_secuencial_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] Dividendo,
    input  logic [N-1:0]   Divisor,
    output logic [N-1:0]   Cociente,
    output logic [N-1:0]   Residuo,
    output logic           busy,
    output logic           done,
    output logic           div_cero,
    output logic           desborde
);

    localparam int CW = cnt_width(N);

`ifdef DIVISOR_SATURA_EN
    localparam logic [N-1:0] Q_DESBORDE = '1;
`else
    localparam logic [N-1:0] Q_DESBORDE = '0;
`endif

    estado_t       estado, estado_sig;
    logic [N:0]    r;
    logic [N-1:0]  l;
    logic [N-1:0]  q;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;
    logic [N:0]    r_nuevo;
    logic          q_bit;
    logic          es_cero;
    logic          es_desborde;
    logic          ultimo;

    divisor_etapa #(.N(N)) u_etapa (
        .r        (r),
        .dato_bit (l[N-1]),
        .d        (d),
        .r_nuevo  (r_nuevo),
        .q_bit    (q_bit)
    );

    always_comb begin
        es_cero     = (Divisor == '0);
        es_desborde = !es_cero && (Dividendo[2*N-1:N] >= Divisor);
        ultimo      = (cnt == CW'(N - 1));
        estado_sig  = estado;
        busy        = 1'b0;
        done        = 1'b0;
        case (estado)
            IDLE: begin
                if (start) begin
                    estado_sig = (es_cero || es_desborde) ? FIN : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (ultimo) begin
                    estado_sig = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                estado_sig = IDLE;
            end
            default: estado_sig = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= IDLE;
            r        <= '0;
            l        <= '0;
            q        <= '0;
            d        <= '0;
            cnt      <= '0;
            Cociente <= '0;
            Residuo  <= '0;
            div_cero <= 1'b0;
            desborde <= 1'b0;
        end else begin
            estado <= estado_sig;
            case (estado)
                IDLE: begin
                    if (start) begin
                        d        <= Divisor;
                        r        <= {1'b0, Dividendo[2*N-1:N]};
                        l        <= Dividendo[N-1:0];
                        q        <= '0;
                        cnt      <= '0;
                        div_cero <= es_cero;
                        desborde <= es_desborde;
                        // Early exits publish their results now so they are valid in FIN.
                        if (es_cero) begin
                            Cociente <= '1;
                            Residuo  <= Dividendo[N-1:0];
                        end else if (es_desborde) begin
                            Cociente <= Q_DESBORDE;
                            Residuo  <= '0;
                        end
                    end
                end
                CALC: begin
                    r   <= r_nuevo;
                    l   <= {l[N-2:0], 1'b0};
                    q   <= {q[N-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                    if (ultimo) begin
                        Cociente <= {q[N-2:0], q_bit};
                        Residuo  <= r_nuevo[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb/tb_divisor_secuencial.sv - directed and randomised self-checking bench for divisor_secuencial
module tb_divisor_secuencial;

    localparam int N = 25;
    localparam int MAX_LAT = 40;

`ifdef DIVISOR_SATURA_EN
    localparam logic [N-1:0] Q_OVF = 25'h1FFFFFF;
`else
    localparam logic [N-1:0] Q_OVF = 25'h0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [2*N-1:0] dividendo;
    logic [N-1:0]   divisor;
    logic [N-1:0]   cociente;
    logic [N-1:0]   residuo;
    logic           busy;
    logic           done;
    logic           div_cero;
    logic           desborde;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    divisor_secuencial #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .Dividendo (dividendo),
        .Divisor   (divisor),
        .Cociente  (cociente),
        .Residuo   (residuo),
        .busy      (busy),
        .done      (done),
        .div_cero  (div_cero),
        .desborde  (desborde)
    );

    // Launches one division and waits (bounded) for done; operands are scrambled after acceptance.
    task automatic run_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                          output int lat, output int busy_cnt,
                          output logic [N-1:0] q, output logic [N-1:0] r,
                          output logic dz, output logic ov);
        @(negedge clk);
        dividendo = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        dividendo = ~a;
        divisor   = ~b;
        lat       = 1;
        busy_cnt  = 0;
        while (!done && lat < MAX_LAT) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        q  = cociente;
        r  = residuo;
        dz = div_cero;
        ov = desborde;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        dividendo = '0;
        divisor = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, div_cero, desborde} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, div_cero, desborde});
        end
        checks++;
        if ({cociente, residuo} !== '0) begin
            errors++;
            $display("FAIL reset_results: got q=%h r=%h expected 0", cociente, residuo);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [N-1:0] q, r;
        logic dz, ov;
        run_op(50'd6, 25'd3, lat, bc, q, r, dz, ov);
        checks++;
        if (lat !== 26) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 26", lat);
        end
        checks++;
        if (bc !== 25) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d expected 25", bc);
        end
        checks++;
        if ({q, r, dz, ov} !== {25'd2, 25'd0, 2'b00}) begin
            errors++;
            $display("FAIL basic_result: got q=%0d r=%0d dz=%b ov=%b expected q=2 r=0 dz=0 ov=0", q, r, dz, ov);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cociente !== 25'd2) begin
            errors++;
            $display("FAIL basic_hold: got done=%b busy=%b q=%0d expected done=0 busy=0 q=2", done, busy, cociente);
        end
    endtask

    task automatic test_values();
        logic [2*N-1:0] a_tab [4];
        logic [N-1:0]   b_tab [4];
        logic [N-1:0]   q_tab [4];
        logic [N-1:0]   r_tab [4];
        int lat, bc;
        logic [N-1:0] q, r;
        logic dz, ov;
        a_tab[0] = 50'd1000;               b_tab[0] = 25'd7;        q_tab[0] = 25'd142;       r_tab[0] = 25'd6;
        a_tab[1] = 50'h3FFFFFC000001;      b_tab[1] = 25'h1FFFFFF;  q_tab[1] = 25'h1FFFFFF;   r_tab[1] = 25'd0;
        a_tab[2] = {25'hFFF, 25'h1FFFFFF}; b_tab[2] = 25'h1000;     q_tab[2] = 25'h1FFFFFF;   r_tab[2] = 25'hFFF;
        a_tab[3] = 50'd0;                  b_tab[3] = 25'd5;        q_tab[3] = 25'd0;         r_tab[3] = 25'd0;
        for (int i = 0; i < 4; i++) begin
            run_op(a_tab[i], b_tab[i], lat, bc, q, r, dz, ov);
            checks++;
            if ({q, r, dz, ov, lat} !== {q_tab[i], r_tab[i], 2'b00, 32'd26}) begin
                errors++;
                $display("FAIL values_%0d: got q=%h r=%h dz=%b ov=%b lat=%0d expected q=%h r=%h dz=0 ov=0 lat=26",
                         i, q, r, dz, ov, lat, q_tab[i], r_tab[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int lat, bc;
        logic [N-1:0] q, r;
        logic dz, ov;
        run_op(50'd33554432, 25'd1, lat, bc, q, r, dz, ov);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL ovf_latency: got %0d expected 1", lat);
        end
        checks++;
        if ({q, r, dz, ov} !== {Q_OVF, 25'd0, 2'b01}) begin
            errors++;
            $display("FAIL ovf_result: got q=%h r=%h dz=%b ov=%b expected q=%h r=0 dz=0 ov=1", q, r, dz, ov, Q_OVF);
        end
        run_op({25'd7, 25'd0}, 25'd7, lat, bc, q, r, dz, ov);
        checks++;
        if ({q, r, dz, ov, lat} !== {Q_OVF, 25'd0, 2'b01, 32'd1}) begin
            errors++;
            $display("FAIL ovf_equal: got q=%h r=%h dz=%b ov=%b lat=%0d expected q=%h r=0 dz=0 ov=1 lat=1",
                     q, r, dz, ov, lat, Q_OVF);
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        logic [N-1:0] q, r;
        logic dz, ov;
        run_op(50'h155, 25'd0, lat, bc, q, r, dz, ov);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL divzero_latency: got %0d expected 1", lat);
        end
        checks++;
        if ({q, r, dz, ov} !== {25'h1FFFFFF, 25'h155, 2'b10}) begin
            errors++;
            $display("FAIL divzero_result: got q=%h r=%h dz=%b ov=%b expected q=1ffffff r=155 dz=1 ov=0", q, r, dz, ov);
        end
        run_op(50'd1000, 25'd7, lat, bc, q, r, dz, ov);
        checks++;
        if ({q, r, dz, ov} !== {25'd142, 25'd6, 2'b00}) begin
            errors++;
            $display("FAIL divzero_flags_clear: got q=%0d r=%0d dz=%b ov=%b expected q=142 r=6 dz=0 ov=0", q, r, dz, ov);
        end
    endtask

    task automatic test_ignore_and_reset();
        int k, dones, lat, bc;
        logic [N-1:0] q, r;
        logic dz, ov;
        @(negedge clk);
        dividendo = 50'd1000;
        divisor   = 25'd7;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < MAX_LAT) begin
            if (k == 5) begin
                dividendo = 50'd6;
                divisor   = 25'd3;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        checks++;
        if ({cociente, residuo, k} !== {25'd142, 25'd6, 32'd26}) begin
            errors++;
            $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d expected q=142 r=6 lat=26", cociente, residuo, k);
        end
        @(negedge clk);
        dividendo = 50'd6;
        divisor   = 25'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 2; j <= 10; j++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, div_cero, desborde, cociente, residuo} !== '0) begin
            errors++;
            $display("FAIL reset_midop: got busy=%b done=%b dz=%b ov=%b q=%h r=%h expected all 0",
                     busy, done, div_cero, desborde, cociente, residuo);
        end
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d active cycles expected 0", dones);
        end
        run_op(50'd1000, 25'd7, lat, bc, q, r, dz, ov);
        checks++;
        if ({q, r, lat} !== {25'd142, 25'd6, 32'd26}) begin
            errors++;
            $display("FAIL reset_recover: got q=%0d r=%0d lat=%0d expected q=142 r=6 lat=26", q, r, lat);
        end
    endtask

    task automatic test_random();
        logic [63:0]    tmp;
        logic [2*N-1:0] a;
        logic [N-1:0]   b, eq, er, q, r;
        logic [N-1:0]   hi;
        logic           edz, eov, dz, ov;
        int             elat, lat, bc;
        for (int i = 0; i < 2000; i++) begin
            tmp = {$urandom(), $urandom()};
            a   = tmp[2*N-1:0];
            b   = N'($urandom_range(0, 33554431));
            if (i % 4 == 1) b = N'($urandom_range(1, 300));
            if (i % 97 == 0) b = '0;
            if ((i % 4 != 3) && b != '0) begin
                hi = a[2*N-1:N] % b;
                a  = {hi, a[N-1:0]};
            end
            edz = (b == '0);
            eov = !edz && (a[2*N-1:N] >= b);
            if (edz) begin
                eq = '1;  er = a[N-1:0]; elat = 1;
            end else if (eov) begin
                eq = Q_OVF; er = '0; elat = 1;
            end else begin
                tmp  = 64'(a) / 64'(b);
                eq   = tmp[N-1:0];
                tmp  = 64'(a) % 64'(b);
                er   = tmp[N-1:0];
                elat = 26;
            end
            run_op(a, b, lat, bc, q, r, dz, ov);
            checks++;
            if ({q, r, dz, ov, lat} !== {eq, er, edz, eov, elat}) begin
                errors++;
                $display("FAIL random_%0d: a=%h b=%h got q=%h r=%h dz=%b ov=%b lat=%0d expected q=%h r=%h dz=%b ov=%b lat=%0d",
                         i, a, b, q, r, dz, ov, lat, eq, er, edz, eov, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_overflow();
        test_div_zero();
        test_ignore_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
